// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 host transmitter definitions: command bytes, timing defaults, FSM states.
// Included by the line filter and the transmitter top.
package ps2_host_tx_pkg;

  localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_ACK        = 8'hFA;

  localparam int PS2_INHIBIT_CYC  = 5000;
  localparam int PS2_START_TO_CYC = 750000;
  localparam int PS2_FRAME_TO_CYC = 100000;
  localparam int PS2_FILT_CYC     = 8;
  localparam int TIMER_W          = 20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_WAIT_EDGE,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_FIN,
    ST_ERR
  } state_e;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioning: 2-FF sync on CLK and DAT, CLK level flips after FILT_CYC equal samples.
// Latency 2+FILT_CYC cycles from pin to level/fall pulse; no backpressure.
module ps2_line_filter
  import ps2_host_tx_pkg::*;
#(
  parameter int FILT_CYC = PS2_FILT_CYC
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic clk_pin_i,
  input  logic dat_pin_i,
  output logic clk_lvl_o,
  output logic clk_fall_o,
  output logic dat_sync_o
);

  localparam int CW = $clog2(FILT_CYC + 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          lvl_q, lvl_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    lvl_d  = lvl_q;
    fall_d = 1'b0;
    cnt_d  = '0;
    if (clk_sync_q[1] != lvl_q) begin
      if (cnt_q == CW'(FILT_CYC - 1)) begin
        lvl_d  = clk_sync_q[1];
        fall_d = ~clk_sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Idle bus floats high, so everything resets to the released level.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      lvl_q      <= 1'b1;
      fall_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], clk_pin_i};
      dat_sync_q <= {dat_sync_q[0], dat_pin_i};
      lvl_q      <= lvl_d;
      fall_q     <= fall_d;
      cnt_q      <= cnt_d;
    end
  end

  assign clk_lvl_o  = lvl_q;
  assign clk_fall_o = fall_q;
  assign dat_sync_o = dat_sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter; oe outputs react 1 cycle after a filtered CLK fall.
// Accepts one byte when idle (tx_valid & tx_ready); requests while busy are dropped, not queued.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYC  = PS2_INHIBIT_CYC,
  parameter int START_TO_CYC = PS2_START_TO_CYC,
  parameter int FRAME_TO_CYC = PS2_FRAME_TO_CYC,
  parameter int FILT_CYC     = PS2_FILT_CYC
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam logic [TIMER_W-1:0] INH_LAST   = TIMER_W'(INHIBIT_CYC - 1);
  localparam logic [TIMER_W-1:0] START_LAST = TIMER_W'(START_TO_CYC - 1);
  localparam logic [TIMER_W-1:0] FRAME_LAST = TIMER_W'(FRAME_TO_CYC - 1);

  state_e               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [7:0]           sh_q, sh_d;
  logic                 par_q, par_d;
  logic [3:0]           bitcnt_q, bitcnt_d;
  logic                 clk_oe_q, clk_oe_d;
  logic                 dat_oe_q, dat_oe_d;
  logic                 ack_err_q, ack_err_d;
  logic                 timeout_q, timeout_d;
  logic                 to_err;

  logic clk_lvl, clk_fall, dat_sync;

  ps2_line_filter #(.FILT_CYC(FILT_CYC)) u_filt (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .clk_pin_i  (ps2_clk_in),
    .dat_pin_i  (ps2_dat_in),
    .clk_lvl_o  (clk_lvl),
    .clk_fall_o (clk_fall),
    .dat_sync_o (dat_sync)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    sh_d      = sh_q;
    par_d     = par_q;
    bitcnt_d  = bitcnt_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    ack_err_d = ack_err_q;
    timeout_d = timeout_q;
    to_err    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        timer_d  = '0;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        if (tx_valid) begin
          sh_d      = tx_data;
          par_d     = odd_parity(tx_data);
          ack_err_d = 1'b0;
          timeout_d = 1'b0;
          clk_oe_d  = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (timer_q == INH_LAST) begin
          dat_oe_d = 1'b1;
          timer_d  = '0;
          state_d  = ST_RTS;
        end
      end
      ST_RTS: begin
        clk_oe_d = 1'b0;
        timer_d  = '0;
        state_d  = ST_WAIT_EDGE;
      end
      // Expiry wins over a coincident fall.
      ST_WAIT_EDGE: begin
        if (timer_q == START_LAST) begin
          to_err = 1'b1;
        end else if (clk_fall) begin
          bitcnt_d = 4'd1;
          dat_oe_d = ~sh_q[0];
          timer_d  = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (timer_q == FRAME_LAST) begin
          to_err = 1'b1;
        end else if (clk_fall) begin
          bitcnt_d = bitcnt_q + 4'd1;
          case (bitcnt_q)
            4'd8:    dat_oe_d = ~par_q;
            4'd9:    dat_oe_d = 1'b0;
            4'd10:   state_d  = ST_ACK;
            default: dat_oe_d = ~sh_q[bitcnt_q[2:0]];
          endcase
        end
      end
      ST_ACK: begin
        if (timer_q == FRAME_LAST) begin
          to_err = 1'b1;
        end else begin
          ack_err_d = dat_sync;
          state_d   = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (timer_q == FRAME_LAST) begin
          to_err = 1'b1;
        end else if (clk_lvl && dat_sync) begin
          timer_d = '0;
          state_d = ST_FIN;
        end
      end
      ST_FIN, ST_ERR: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (to_err) begin
      state_d   = ST_ERR;
      timeout_d = 1'b1;
      clk_oe_d  = 1'b0;
      dat_oe_d  = 1'b0;
      timer_d   = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      sh_q      <= '0;
      par_q     <= 1'b0;
      bitcnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sh_q      <= sh_d;
      par_q     <= par_d;
      bitcnt_q  <= bitcnt_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      ack_err_q <= ack_err_d;
      timeout_q <= timeout_d;
    end
  end

  assign tx_ready   = (state_q == ST_IDLE);
  assign busy       = ~tx_ready;
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign done       = (state_q == ST_FIN) || (state_q == ST_ERR);
  assign ack_err    = ack_err_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector bus, behavioural keyboard, busy/flag model, directed tests.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH    = 50;
  localparam int START  = 1000;
  localparam int FRAME  = 1500;
  localparam int FILT   = 8;
  localparam int HALF   = 40;
  localparam int BUDGET = 4000;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, ps2_clk_oe, ps2_dat_oe, done, ack_err, timeout;
  logic       ps2_clk_in, ps2_dat_in;
  logic       dev_clk_low, dev_dat_low;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYC (INH),
    .START_TO_CYC(START),
    .FRAME_TO_CYC(FRAME),
    .FILT_CYC    (FILT)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .done      (done),
    .ack_err   (ack_err),
    .timeout   (timeout)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame as seen on DAT: {stop, odd parity, data LSB-first, start}
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic p;
    p = (($countones(d) % 2) == 0);
    return {1'b1, p, d, 1'b0};
  endfunction

  int cyc = 0;
  int accept_cnt = 0;
  always @(posedge CLOCK_50) begin
    cyc <= cyc + 1;
    if (!reset && tx_valid && tx_ready) accept_cnt <= accept_cnt + 1;
  end

  // Transfer-level model: busy from accept until the cycle after done.
  logic       exp_busy;
  logic [1:0] exp_flags;
  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) exp_busy <= 1'b0;
    else if (!exp_busy && tx_valid) exp_busy <= 1'b1;
    else if (exp_busy && done) exp_busy <= 1'b0;
  end

  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (!reset) begin
        check("ready_busy", {30'd0, tx_ready, busy}, {30'd0, ~exp_busy, exp_busy});
        if (!exp_busy) check("idle_oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        if (done) check("done_flags", {30'd0, ack_err, timeout}, {30'd0, exp_flags});
      end
    end
  end

  // Keyboard model. Modes: 0 ack, 1 silent, 2 stop after 5 edges, 3 no ack, 4 ack + CLK glitch.
  int          dev_mode = 0;
  int          dev_active = 0;
  logic [10:0] rx_q[$];
  initial begin
    logic [10:0] bits;
    logic        full;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (ps2_clk_oe && ps2_dat_oe) begin
        while (ps2_clk_oe) @(negedge CLOCK_50);
        if (dev_mode != 1) begin
          dev_active = 1;
          full = 1'b1;
          bits = '0;
          bits[0] = ps2_dat_in;
          for (int k = 1; k <= 11; k++) begin
            if (dev_mode == 2 && k == 6) begin
              full = 1'b0;
              break;
            end
            repeat (HALF) @(negedge CLOCK_50);
            if (k == 11 && dev_mode != 3) dev_dat_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge CLOCK_50);
            dev_clk_low = 1'b0;
            if (k <= 10) bits[k] = ps2_dat_in;
            if (dev_mode == 4 && k == 4) begin
              repeat (HALF / 2) @(negedge CLOCK_50);
              #9 dev_clk_low = 1'b1;
              #2 dev_clk_low = 1'b0;
            end
          end
          dev_dat_low = 1'b0;
          if (full) rx_q.push_back(bits);
          dev_active = 0;
        end
      end
    end
  end

  // Bus monitor: inhibit length, RTS overlap, release/data timestamps, DAT changes while CLK high.
  int   clk_oe_run = 0, last_run = 0, overlap_cnt = 0, done_cnt = 0, chg_viol = 0;
  int   t_release = 0, t_dat_fall = -1;
  logic prev_clk_oe = 1'b0, prev_dat_oe = 1'b0;
  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (!reset) begin
        if (ps2_clk_oe) clk_oe_run++;
        else if (prev_clk_oe) begin
          last_run   = clk_oe_run;
          clk_oe_run = 0;
          t_release  = cyc;
        end
        if (ps2_clk_oe && ps2_dat_oe) overlap_cnt++;
        if (prev_dat_oe && !ps2_dat_oe && !ps2_clk_oe && t_dat_fall < 0) t_dat_fall = cyc;
        if (ps2_dat_oe != prev_dat_oe && ps2_clk_in && !done) chg_viol++;
        if (done) done_cnt++;
      end
      prev_clk_oe = ps2_clk_oe;
      prev_dat_oe = ps2_dat_oe;
    end
  end

  task automatic send(input logic [7:0] d);
    @(negedge CLOCK_50);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int t_done);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    t_done = cyc;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s: done=0 after %0d cycles, expected 1", name, n);
    end
  endtask

  task automatic check_frame(input string name, input logic [7:0] d, output logic [10:0] f);
    f = 11'h7FF;
    if (rx_q.size() > 0) f = rx_q.pop_front();
    check(name, {21'd0, f}, {21'd0, exp_frame(d)});
  endtask

  initial begin
    int          td, n, d, a0, dc0;
    logic [10:0] f;
    reset     = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    exp_flags = 2'b00;
    repeat (3) @(negedge CLOCK_50);
    check("reset_outputs", {25'd0, tx_ready, busy, ps2_clk_oe, ps2_dat_oe, done, ack_err, timeout},
          32'b1000000);
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);

    // 1: set-LEDs command with ACK
    dev_mode = 0; exp_flags = 2'b00; overlap_cnt = 0;
    send(PS2_CMD_LEDS);
    wait_done("t1_done", BUDGET, td);
    check("t1_flags", {30'd0, ack_err, timeout}, 32'd0);
    check_frame("t1_frame", PS2_CMD_LEDS, f);
    check("t1_frame_lit", {21'd0, f}, 32'b1_1_11101101_0);
    check("t1_inhibit_len", 32'(last_run >= INH), 32'd1);
    check("t1_rts_overlap", 32'(overlap_cnt), 32'd1);
    repeat (20) @(negedge CLOCK_50);
    check("t1_flags_hold", {30'd0, ack_err, timeout}, 32'd0);

    // 2: parity extremes
    send(8'h00);
    wait_done("t2a_done", BUDGET, td);
    check_frame("t2a_frame", 8'h00, f);
    check("t2a_parity_lit", {31'd0, f[9]}, 32'd1);
    send(8'h01);
    wait_done("t2b_done", BUDGET, td);
    check_frame("t2b_frame", 8'h01, f);
    check("t2b_parity_lit", {31'd0, f[9]}, 32'd0);

    // 3: device never clocks
    dev_mode = 1; exp_flags = 2'b01;
    send(PS2_CMD_ECHO);
    wait_done("t3_done", START + INH + 500, td);
    check("t3_oe_at_done", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check("t3_start_to", 32'(td - t_release), 32'(START));
    repeat (20) @(negedge CLOCK_50);
    check("t3_timeout_hold", {30'd0, ack_err, timeout}, 32'b01);

    // 4a: device stops after 5 edges
    dev_mode = 2; exp_flags = 2'b01; t_dat_fall = -1;
    send(PS2_CMD_LEDS);
    wait_done("t4a_done", FRAME + INH + 1000, td);
    check("t4a_frame_to", 32'(td - t_dat_fall), 32'(FRAME));

    // 4b: no ACK from device
    dev_mode = 3; exp_flags = 2'b10;
    send(PS2_CMD_ENABLE);
    wait_done("t4b_done", BUDGET, td);
    check("t4b_flags", {30'd0, ack_err, timeout}, 32'b10);
    check_frame("t4b_frame", PS2_CMD_ENABLE, f);
    repeat (20) @(negedge CLOCK_50);
    check("t4b_ack_err_hold", {30'd0, ack_err, timeout}, 32'b10);

    // 5: reset in the middle of SHIFT
    dev_mode = 0; exp_flags = 2'b00;
    send(PS2_CMD_LEDS);
    repeat (INH + 5 * HALF) @(negedge CLOCK_50);
    check("t5_busy_before", {31'd0, busy}, 32'd1);
    dc0 = done_cnt;
    #3 reset = 1'b1;
    #1 check("t5_async_release", {28'd0, ps2_clk_oe, ps2_dat_oe, tx_ready, done}, 32'b0010);
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    n = 0;
    while (dev_active != 0 && n < BUDGET) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("t5_dev_finished", 32'(dev_active), 32'd0);
    check("t5_no_done", 32'(done_cnt - dc0), 32'd0);
    rx_q.delete();
    send(PS2_CMD_ENABLE);
    wait_done("t5_done", BUDGET, td);
    check_frame("t5_frame", PS2_CMD_ENABLE, f);

    // 6: tx_valid held across two frames, CLK glitch inside each frame
    dev_mode = 4; exp_flags = 2'b00;
    repeat (5) @(negedge CLOCK_50);
    a0 = accept_cnt;
    tx_data  = PS2_CMD_ECHO;
    tx_valid = 1'b1;
    n = 0; d = 0;
    while (d < 2 && n < 2 * BUDGET) begin
      @(negedge CLOCK_50);
      n++;
      if (done) d++;
    end
    tx_valid = 1'b0;
    check("t6_dones", 32'(d), 32'd2);
    repeat (20) @(negedge CLOCK_50);
    check("t6_accepts", 32'(accept_cnt - a0), 32'd2);
    check("t6_frame_cnt", 32'(rx_q.size()), 32'd2);
    check_frame("t6_frame0", PS2_CMD_ECHO, f);
    check_frame("t6_frame1", PS2_CMD_ECHO, f);

    check("dat_changes_clk_high", 32'(chg_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
